// File: rtl/tempo_pkg.sv
// Shared tempo definitions: BPM table, sub-tick period math and FSM state encoding.
package tempo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } tempo_state_e;

  localparam int unsigned NUM_SPEEDS = 8;
  localparam int unsigned BPM_TAB [NUM_SPEEDS] = '{40, 60, 80, 100, 120, 140, 180, 220};

  // Rounded clk cycles per sub-tick; 64-bit intermediate since CLK_HZ*60 can exceed 32 bits.
  function automatic logic [31:0] tempo_period(input int unsigned clk_hz,
                                               input int unsigned bpm,
                                               input int unsigned subdiv);
    logic [63:0] num, den;
    den = 64'(bpm) * 64'(subdiv);
    num = 64'(clk_hz) * 64'd60 + den / 64'd2;
    return 32'(num / den);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/tempo_tick_gen_if.sv
// Control inputs and tick/position outputs of the tempo generator.
interface tempo_tick_gen_if
  import tempo_pkg::*;
#(
  parameter int unsigned SUBDIV        = 4,
  parameter int unsigned BEATS_PER_BAR = 4,
  parameter int unsigned BAR_W         = 8
) ();
  localparam int unsigned SUB_W  = idx_w(SUBDIV);
  localparam int unsigned BEAT_W = idx_w(BEATS_PER_BAR);

  logic [2:0]        speed;
  logic              run;
  logic              restart;
  logic              sub_tick;
  logic              beat_tick;
  logic              bar_tick;
  logic [SUB_W-1:0]  sub_idx;
  logic [BEAT_W-1:0] beat_idx;
  logic [BAR_W-1:0]  bar_cnt;
  logic              running;

  modport master (
    output speed, run, restart,
    input  sub_tick, beat_tick, bar_tick, sub_idx, beat_idx, bar_cnt, running
  );

  modport slave (
    input  speed, run, restart,
    output sub_tick, beat_tick, bar_tick, sub_idx, beat_idx, bar_cnt, running
  );
endinterface

// File: rtl/tempo_period_rom.sv
// Combinational speed -> sub-tick period lookup; every entry is an elaboration-time constant.
module tempo_period_rom
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned SUBDIV = 4
) (
  input  logic [2:0]  speed,
  output logic [31:0] period
);
  logic [NUM_SPEEDS-1:0][31:0] p_tab;

  for (genvar i = 0; i < NUM_SPEEDS; i++) begin : g_tab
    localparam logic [31:0] P = tempo_period(CLK_HZ, BPM_TAB[i], SUBDIV);
    assign p_tab[i] = P;
  end

  assign period = p_tab[speed];
endmodule

// File: rtl/tempo_tick_gen.sv
// Metronome: sub-beat/beat/bar strobes at one of 8 tempos with run/pause, restart and position tracking.
module tempo_tick_gen
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned SUBDIV        = 4,
  parameter int unsigned BEATS_PER_BAR = 4,
  parameter int unsigned BAR_W         = 8
) (
  input  logic            clk,
  input  logic            resetn,
  tempo_tick_gen_if.slave tif
);
  localparam int unsigned       SUB_W     = idx_w(SUBDIV);
  localparam int unsigned       BEAT_W    = idx_w(BEATS_PER_BAR);
  localparam logic [31:0]       PER_RST   = tempo_period(CLK_HZ, BPM_TAB[0], SUBDIV);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUBDIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_BAR - 1);

  tempo_state_e      state, state_nx;
  logic [31:0]       cnt, per, p_sel;
  logic [SUB_W-1:0]  sub_idx;
  logic [BEAT_W-1:0] beat_idx;
  logic [BAR_W-1:0]  bar_cnt;
  logic              sub_tick, sub_wrap, beat_wrap;

  tempo_period_rom #(.CLK_HZ(CLK_HZ), .SUBDIV(SUBDIV)) u_rom (
    .speed  (tif.speed),
    .period (p_sel)
  );

  // Gated by resetn so a reset cycle never strobes, even with cnt==0 in RUN.
  assign sub_tick  = resetn & (state == RUN) & (cnt == 32'd0);
  assign sub_wrap  = (sub_idx == SUB_LAST);
  assign beat_wrap = (beat_idx == BEAT_LAST);

  always_comb begin
    state_nx = state;
    if (!tif.restart) begin
      case (state)
        IDLE:    if (tif.run)  state_nx = RUN;
        RUN:     if (!tif.run) state_nx = PAUSE;
        PAUSE:   if (tif.run)  state_nx = RUN;
        default:               state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      per      <= PER_RST;
      sub_idx  <= '0;
      beat_idx <= '0;
      bar_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) per <= p_sel;
      if (tif.restart) begin
        cnt      <= '0;
        sub_idx  <= '0;
        beat_idx <= '0;
        bar_cnt  <= '0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (state == RUN) begin
        if (sub_tick) begin
          // Speed is sampled only here, so a tempo change never shortens the running interval.
          per <= p_sel;
          cnt <= p_sel - 32'd1;
          if (sub_wrap) begin
            sub_idx <= '0;
            if (beat_wrap) begin
              beat_idx <= '0;
              bar_cnt  <= bar_cnt + 1'b1;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end else begin
            sub_idx <= sub_idx + 1'b1;
          end
        end else begin
          cnt <= cnt - 32'd1;
        end
      end
    end
  end

  cnt_in_period: assert property (@(posedge clk) disable iff (!resetn)
                                  (state == RUN) |-> (cnt < per));

  assign tif.sub_tick  = sub_tick;
  assign tif.beat_tick = sub_tick & (sub_idx == '0);
  assign tif.bar_tick  = sub_tick & (sub_idx == '0) & (beat_idx == '0);
  assign tif.sub_idx   = sub_idx;
  assign tif.beat_idx  = beat_idx;
  assign tif.bar_cnt   = bar_cnt;
  assign tif.running   = (state == RUN);
endmodule

// File: tb/tb_tempo_tick_gen.sv
// Self-checking bench: event-level tempo model (interval + tick count) against the DUT, scenario tasks plus random stimulus.
module tb_tempo_tick_gen;
  localparam int unsigned CLK_HZ = 1200;
  localparam int unsigned SUBDIV = 2;
  localparam int unsigned BPB    = 4;
  localparam int unsigned BAR_W  = 2;
  localparam int          BPMS [8] = '{40, 60, 80, 100, 120, 140, 180, 220};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tempo_tick_gen_if #(.SUBDIV(SUBDIV), .BEATS_PER_BAR(BPB), .BAR_W(BAR_W)) tif ();

  tempo_tick_gen #(.CLK_HZ(CLK_HZ), .SUBDIV(SUBDIV), .BEATS_PER_BAR(BPB), .BAR_W(BAR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .tif    (tif)
  );

  // {sub, beat, bar, running, sub_idx[0], beat_idx[1:0], bar_cnt[1:0]}
  logic [8:0] got;
  assign got = {tif.sub_tick, tif.beat_tick, tif.bar_tick, tif.running,
                tif.sub_idx, tif.beat_idx, tif.bar_cnt};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: mode (0 idle, 1 run, 2 pause), RUN cycles since last tick, current interval,
  // ticks since position 0, and whether a downbeat is owed on the next RUN cycle.
  int mst   = 0;
  int since = 0;
  int ivl   = 0;
  int pos   = 0;
  bit first = 1'b1;

  function automatic int per_of(input int s);
    int b;
    b = BPMS[s];
    return (int'(CLK_HZ) * 60 + b * int'(SUBDIV) / 2) / (b * int'(SUBDIV));
  endfunction

  function automatic logic [8:0] exp_vec();
    logic tk, bt, br;
    tk = resetn && (mst == 1) && (first || since == ivl);
    bt = tk && (pos % SUBDIV == 0);
    br = bt && ((pos / SUBDIV) % BPB == 0);
    return {tk, bt, br, (mst == 1), 1'(pos % SUBDIV), 2'((pos / SUBDIV) % BPB),
            2'((pos / (SUBDIV * BPB)) % 4)};
  endfunction

  // Advances the model with the inputs the DUT will sample at the next edge, then samples at negedge.
  task automatic step(output logic [8:0] g, output logic [8:0] e);
    logic [8:0] v;
    v = exp_vec();
    if (!resetn) begin
      mst = 0; first = 1'b1; pos = 0; since = 0; ivl = per_of(0);
    end else if (tif.restart) begin
      first = 1'b1; pos = 0; since = 0;
    end else begin
      if (mst == 1) begin
        if (v[8]) begin
          pos++; ivl = per_of(int'(tif.speed)); since = 1; first = 1'b0;
        end else since++;
      end else if (mst == 0) first = 1'b1;
      case (mst)
        0: if (tif.run)  mst = 1;
        1: if (!tif.run) mst = 2;
        2: if (tif.run)  mst = 1;
        default: ;
      endcase
    end
    @(negedge clk);
    cyc++;
    g = got;
    e = exp_vec();
  endtask

  task automatic test_reset();
    logic [8:0] g, e;
    int t_sub, t_beat, t_bar, nbar;
    tif.run = 1'b1; tif.speed = 3'd4; tif.restart = 1'b0; resetn = 1'b0;
    repeat (3) begin
      step(g, e); checks++;
      if (g !== e || g !== 9'd0) begin errors++; $display("FAIL reset_state: got %b want %b", g, 9'd0); end
    end
    resetn = 1'b1;
    step(g, e); checks++;
    if (g !== 9'b1_1110_0000) begin errors++; $display("FAIL first_downbeat: got %b want %b", g, 9'b111100000); end
    t_sub = cyc; t_beat = cyc; t_bar = cyc; nbar = 1;
    for (int c = 0; c < 6000 && nbar < 2; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_run cyc %0d: got %b want %b", cyc, g, e); end
      if (g[8]) begin
        checks++;
        if (cyc - t_sub != 300) begin errors++; $display("FAIL sub_period: got %0d want 300", cyc - t_sub); end
        t_sub = cyc;
      end
      if (g[7]) begin
        checks++;
        if (cyc - t_beat != 600) begin errors++; $display("FAIL beat_period: got %0d want 600", cyc - t_beat); end
        t_beat = cyc;
      end
      if (g[6]) begin
        nbar++; checks++;
        if (cyc - t_bar != 2400 || g[1:0] !== 2'd1)
          begin errors++; $display("FAIL bar_period: got %0d bar %0d want 2400 bar 1", cyc - t_bar, g[1:0]); end
        t_bar = cyc;
      end
    end
    checks++;
    if (nbar < 2) begin errors++; $display("FAIL bar_timeout: got %0d bars want 2", nbar); end
  endtask

  task automatic test_tempo_change();
    logic [8:0] g, e;
    int t0, n;
    tif.speed = 3'd0; tif.restart = 1'b1;
    step(g, e); checks++;
    if (g !== 9'b1_1110_0000) begin errors++; $display("FAIL tc_downbeat: got %b want %b", g, 9'b111100000); end
    tif.restart = 1'b0; t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int c = 0; c < 1000 && n == 0; c++) begin
        if (cyc - t0 == 400) tif.speed = 3'd2;
        step(g, e); checks++;
        if (g !== e) begin errors++; $display("FAIL tempo_change cyc %0d: got %b want %b", cyc, g, e); end
        if (g[8]) n = cyc - t0;
      end
      checks++;
      if (n != (k == 0 ? 900 : 450)) begin errors++; $display("FAIL tc_interval%0d: got %0d want %0d", k, n, k == 0 ? 900 : 450); end
      t0 = cyc;
    end
  endtask

  task automatic test_pause();
    logic [8:0] g, e, held;
    int n;
    tif.speed = 3'd4;
    n = 0;
    for (int c = 0; c < 500 && n == 0; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL pause_sync: got %b want %b", g, e); end
      if (g[8]) n = 1;
    end
    repeat (100) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL pause_pre: got %b want %b", g, e); end
    end
    tif.run = 1'b0; held = e;
    repeat (137) begin
      step(g, e); checks++;
      if (g[8:5] !== 4'd0 || g[4:0] !== held[4:0] || g !== e)
        begin errors++; $display("FAIL paused: got %b want %b", g, {4'd0, held[4:0]}); end
    end
    tif.run = 1'b1; n = 0;
    for (int c = 1; c <= 300 && n == 0; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL pause_resume: got %b want %b", g, e); end
      if (g[8]) n = c;
    end
    checks++;
    if (n != 200) begin errors++; $display("FAIL resume_phase: got %0d want 200", n); end
  endtask

  task automatic test_restart();
    logic [8:0] g, e;
    int t0, n;
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL rs_seek: got %b want %b", g, e); end
      hit = e[5] && !e[8] && e[4] && (e[3:2] == 2'd2);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rs_timeout: got no beat2/sub1 want one"); end
    tif.restart = 1'b1;
    step(g, e); checks++;
    if (g !== 9'b1_1110_0000) begin errors++; $display("FAIL rs_downbeat: got %b want %b", g, 9'b111100000); end
    tif.restart = 1'b0; t0 = cyc; n = 0;
    for (int c = 0; c < 400 && n == 0; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL rs_run: got %b want %b", g, e); end
      if (g[8]) n = cyc - t0;
    end
    checks++;
    if (n != 300) begin errors++; $display("FAIL rs_cadence: got %0d want 300", n); end
  endtask

  task automatic test_bar_wrap();
    logic [8:0] g, e;
    int k, t0;
    tif.speed = 3'd7; tif.restart = 1'b1;
    step(g, e); checks++;
    if (g[6] !== 1'b1 || g[1:0] !== 2'd0) begin errors++; $display("FAIL bw_start: got %b want bar_tick bar 0", g); end
    tif.restart = 1'b0; k = 0; t0 = cyc;
    for (int c = 0; c < 7000 && k < 4; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL bw_run: got %b want %b", g, e); end
      if (g[6]) begin
        k++; checks++;
        if (g[1:0] !== 2'(k % 4) || cyc - t0 != 1312)
          begin errors++; $display("FAIL bar_seq: got bar %0d gap %0d want bar %0d gap 1312", g[1:0], cyc - t0, k % 4); end
        t0 = cyc;
      end
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL bw_timeout: got %0d bars want 4", k); end
  endtask

  task automatic test_mid_reset();
    logic [8:0] g, e;
    bit hit;
    tif.speed = 3'd4; hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL mr_seek: got %b want %b", g, e); end
      hit = g[8];
    end
    resetn = 1'b0; #1;
    checks++;
    if (got[8:6] !== 3'b000) begin errors++; $display("FAIL reset_cycle_tick: got %b want 000", got[8:6]); end
    step(g, e); checks++;
    if (g !== 9'd0) begin errors++; $display("FAIL mr_idle: got %b want %b", g, 9'd0); end
    resetn = 1'b1;
    step(g, e); checks++;
    if (g !== 9'b1_1110_0000) begin errors++; $display("FAIL mr_downbeat: got %b want %b", g, 9'b111100000); end
  endtask

  task automatic test_random();
    logic [8:0] g, e;
    for (int c = 0; c < 4000; c++) begin
      step(g, e); checks++;
      if (g !== e) begin errors++; $display("FAIL random cyc %0d: got %b want %b", cyc, g, e); end
      if ($urandom_range(0, 99) < 3) tif.run = ~tif.run;
      tif.restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) tif.speed = 3'($urandom_range(0, 7));
      resetn = ($urandom_range(0, 799) != 0);
    end
    resetn = 1'b1; tif.restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tempo_change();
    test_pause();
    test_restart();
    test_bar_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
